// File: rtl/sp_instr_fifo_pkg.sv
// Shared types for the scratchpad read-instruction FIFO: the four-port
// (matrix, row) selection word and default sizing constants.
package sp_instr_fifo_pkg;

    localparam int SP_INSTR_FIFO_DEPTH  = 8;
    localparam int SP_INSTR_FIFO_AFULL  = 6;
    localparam int SP_NUM_RD_PORTS      = 4;
    localparam int SP_MAT_W             = 3;
    localparam int SP_ROW_W             = 4;

    typedef logic [SP_MAT_W-1:0] mat_s_t;
    typedef logic [SP_ROW_W-1:0] row_s_t;

    // Element 0 is read port 1, element 3 is read port 4.
    typedef struct packed {
        mat_s_t [SP_NUM_RD_PORTS-1:0] mat_sel;
        row_s_t [SP_NUM_RD_PORTS-1:0] row_sel;
    } rd_instr_t;

    function automatic int sp_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sp_instr_fifo_if.sv
// Read-side handshake between the instruction FIFO and the output-FIFO read FSM.
interface sp_instr_fifo_if;
    import sp_instr_fifo_pkg::*;

    logic      instr_FIFO_REN;
    logic      instr_FIFO_empty;
    rd_instr_t instr_rdata;

    modport fifo (
        input  instr_FIFO_REN,
        output instr_FIFO_empty,
        output instr_rdata
    );

    modport fsm (
        output instr_FIFO_REN,
        input  instr_FIFO_empty,
        input  instr_rdata
    );

endinterface

// File: rtl/sp_instr_fifo.sv
// Circular show-ahead instruction buffer between the scratchpad request decoder
// and the output-FIFO read FSM; occupancy kept in an explicit count register.
module sp_instr_fifo
    import sp_instr_fifo_pkg::*;
#(
    parameter int DEPTH        = SP_INSTR_FIFO_DEPTH,
    parameter int AFULL_THRESH = SP_INSTR_FIFO_AFULL
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   clear,
    input  logic                   instr_WEN,
    input  rd_instr_t              instr_wdata,
    output logic                   instr_FIFO_full,
    output logic                   instr_FIFO_afull,
    sp_instr_fifo_if.fifo          rd_if,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_flush;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    rd_instr_t     w_mem [DEPTH];

    // Status decodes look only at the registered count, never at WEN/REN.
    assign w_flush = !nRST || clear;
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = instr_WEN && !w_full && !w_flush;
    assign w_pop   = rd_if.instr_FIFO_REN && !w_empty && !w_flush;

    always_ff @(posedge CLK) begin
        if (w_flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (instr_WEN && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_if.instr_FIFO_REN && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately outside the flush path: clearing only moves pointers.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        rd_instr_t r_entry;

        always_ff @(posedge CLK) begin
            if (w_push && (r_wptr == AW'(gi))) begin
                r_entry <= instr_wdata;
            end
        end

        assign w_mem[gi] = r_entry;
    end

    assign rd_if.instr_rdata      = w_mem[r_rptr];
    assign rd_if.instr_FIFO_empty = w_empty;
    assign instr_FIFO_full        = w_full;
    assign instr_FIFO_afull       = (r_count >= AFULL_CNT);
    assign count                  = r_count;
    assign overflow               = r_overflow;
    assign underflow              = r_underflow;

endmodule

// File: tb/tb_sp_instr_fifo.sv
// Self-checking bench for sp_instr_fifo: directed vector table, hand sequences
// for wrap/throughput/flush, and random traffic against a queue-based model.
module tb_sp_instr_fifo;
    import sp_instr_fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic       CLK;
    logic       nRST;
    logic       clear;
    logic       instr_WEN;
    rd_instr_t  instr_wdata;
    logic       instr_FIFO_full;
    logic       instr_FIFO_afull;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    sp_instr_fifo_if rd_if();

    sp_instr_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .clear            (clear),
        .instr_WEN        (instr_WEN),
        .instr_wdata      (instr_wdata),
        .instr_FIFO_full  (instr_FIFO_full),
        .instr_FIFO_afull (instr_FIFO_afull),
        .rd_if            (rd_if),
        .count            (count),
        .overflow         (overflow),
        .underflow        (underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a plain queue plus two sticky bits.
    rd_instr_t m_q[$];
    bit        m_ovf = 1'b0;
    bit        m_unf = 1'b0;

    typedef struct {
        bit        nrst;
        bit        clr;
        bit        wen;
        bit        ren;
        rd_instr_t wd;
        int        e_count;
        bit        e_empty;
        bit        e_full;
        bit        e_afull;
        bit        e_ovf;
        bit        e_unf;
        bit        e_chk;
        rd_instr_t e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic rd_instr_t mk(input int v);
        rd_instr_t r;
        for (int k = 0; k < 4; k++) begin
            r.mat_sel[k] = 3'(v + k);
            r.row_sel[k] = 4'(v * 3 + k);
        end
        return r;
    endfunction

    function automatic rd_instr_t instr_a();
        rd_instr_t r;
        r.mat_sel[0] = 3'd1; r.mat_sel[1] = 3'd2; r.mat_sel[2] = 3'd3; r.mat_sel[3] = 3'd0;
        r.row_sel[0] = 4'd0; r.row_sel[1] = 4'd1; r.row_sel[2] = 4'd2; r.row_sel[3] = 4'd3;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_edge(input bit nrst, input bit clr, input bit wen,
                                       input bit ren, input rd_instr_t wd);
        int sz;
        sz = m_q.size();
        if (!nrst || clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wen && sz == DEPTH) m_ovf = 1'b1;
            if (ren && sz == 0)     m_unf = 1'b1;
            if (ren && sz > 0)      void'(m_q.pop_front());
            if (wen && sz < DEPTH)  m_q.push_back(wd);
        end
    endfunction

    task automatic model_check();
        int sz;
        sz = m_q.size();
        chk("m_count", 32'(count), 32'(sz));
        chk("m_empty", 32'(rd_if.instr_FIFO_empty), 32'(sz == 0));
        chk("m_full",  32'(instr_FIFO_full), 32'(sz == DEPTH));
        chk("m_afull", 32'(instr_FIFO_afull), 32'(sz >= AFULL));
        chk("m_ovf",   32'(overflow), 32'(m_ovf));
        chk("m_unf",   32'(underflow), 32'(m_unf));
        if (sz > 0) chk("m_rdata", 32'(rd_if.instr_rdata), 32'(m_q[0]));
    endtask

    task automatic step(input bit nrst, input bit clr, input bit wen, input bit ren,
                        input rd_instr_t wd);
        nRST                 = nrst;
        clear                = clr;
        instr_WEN            = wen;
        rd_if.instr_FIFO_REN = ren;
        instr_wdata          = wd;
        @(posedge CLK);
        model_edge(nrst, clr, wen, ren, wd);
        #1;
        $display("t=%0t nrst=%0b clr=%0b wen=%0b ren=%0b wd=%07h -> cnt=%0d emp=%0b full=%0b afull=%0b ovf=%0b unf=%0b rd=%07h",
                 $time, nrst, clr, wen, ren, wd, count, rd_if.instr_FIFO_empty,
                 instr_FIFO_full, instr_FIFO_afull, overflow, underflow, rd_if.instr_rdata);
        model_check();
    endtask

    function automatic void add(input bit nrst, input bit clr, input bit wen, input bit ren,
                                input rd_instr_t wd, input int e_count, input bit e_ovf,
                                input bit e_unf, input bit e_chk, input rd_instr_t e_rdata);
        vec_t v;
        v.nrst = nrst; v.clr = clr; v.wen = wen; v.ren = ren; v.wd = wd;
        v.e_count = e_count;
        v.e_empty = (e_count == 0);
        v.e_full  = (e_count == DEPTH);
        v.e_afull = (e_count >= AFULL);
        v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_chk = e_chk; v.e_rdata = e_rdata;
        vecs.push_back(v);
    endfunction

    initial begin
        rd_instr_t z;
        z = '0;

        // Reset, idle, pop-while-empty, push A / pop A, then flush.
        add(0, 0, 0, 0, z, 0, 0, 0, 0, z);
        add(1, 0, 0, 0, z, 0, 0, 0, 0, z);
        add(1, 0, 0, 1, z, 0, 0, 1, 0, z);
        add(1, 0, 1, 0, instr_a(), 1, 0, 1, 1, instr_a());
        add(1, 0, 0, 1, z, 0, 0, 1, 0, z);
        add(1, 1, 0, 0, z, 0, 0, 0, 0, z);
        // Fill 0..7, one overflowing push, then drain in order.
        for (int k = 1; k <= DEPTH; k++) add(1, 0, 1, 0, mk(k - 1), k, 0, 0, 1, mk(0));
        add(1, 0, 1, 0, mk(33), DEPTH, 1, 0, 1, mk(0));
        for (int k = 1; k <= DEPTH; k++) add(1, 0, 0, 1, z, DEPTH - k, 1, 0, k < DEPTH, mk(k));

        nRST = 1'b0; clear = 1'b0; instr_WEN = 1'b0; rd_if.instr_FIFO_REN = 1'b0; instr_wdata = z;

        foreach (vecs[i]) begin
            step(vecs[i].nrst, vecs[i].clr, vecs[i].wen, vecs[i].ren, vecs[i].wd);
            chk("v_count", 32'(count), 32'(vecs[i].e_count));
            chk("v_empty", 32'(rd_if.instr_FIFO_empty), 32'(vecs[i].e_empty));
            chk("v_full",  32'(instr_FIFO_full), 32'(vecs[i].e_full));
            chk("v_afull", 32'(instr_FIFO_afull), 32'(vecs[i].e_afull));
            chk("v_ovf",   32'(overflow), 32'(vecs[i].e_ovf));
            chk("v_unf",   32'(underflow), 32'(vecs[i].e_unf));
            if (vecs[i].e_chk) chk("v_rdata", 32'(rd_if.instr_rdata), 32'(vecs[i].e_rdata));
        end

        // Wrap-around: offset pointers by 5, then 8 words across the wrap.
        step(1, 1, 0, 0, z);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, mk(20 + i));
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, z);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, mk(40 + i));
        chk("wrap_full", 32'(instr_FIFO_full), 32'(1));
        for (int i = 0; i < 8; i++) begin
            chk("wrap_rd", 32'(rd_if.instr_rdata), 32'(mk(40 + i)));
            step(1, 0, 0, 1, z);
        end
        chk("wrap_empty", 32'(rd_if.instr_FIFO_empty), 32'(1));

        // Full-throughput push+pop at a steady occupancy of 3.
        step(1, 1, 0, 0, z);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, mk(60 + i));
        for (int c = 0; c < 20; c++) begin
            chk("thru_rd", 32'(rd_if.instr_rdata), 32'(mk(60 + c)));
            step(1, 0, 1, 1, mk(63 + c));
            chk("thru_cnt", 32'(count), 32'(3));
        end

        // Flush with simultaneous WEN/REN, first by clear, then by reset.
        for (int pass = 0; pass < 2; pass++) begin
            step(1, 1, 0, 0, z);
            step(1, 0, 0, 1, z);
            for (int i = 0; i < 4; i++) step(1, 0, 1, 0, mk(80 + i));
            chk("fl_pre_unf", 32'(underflow), 32'(1));
            step(pass == 1 ? 1'b0 : 1'b1, pass == 0, 1, 1, mk(99));
            chk("fl_count", 32'(count), 32'(0));
            chk("fl_empty", 32'(rd_if.instr_FIFO_empty), 32'(1));
            chk("fl_flags", 32'({overflow, underflow}), 32'(0));
            step(1, 0, 0, 0, z);
            chk("fl_nostore", 32'(rd_if.instr_FIFO_empty), 32'(1));
            step(1, 0, 1, 0, mk(100 + pass));
            chk("fl_push", 32'(rd_if.instr_rdata), 32'(mk(100 + pass)));
        end

        // Random traffic: fill-biased phase then drain-biased phase.
        for (int c = 0; c < 600; c++) begin
            int wp;
            int rp;
            wp = (c < 300) ? 70 : 40;
            rp = (c < 300) ? 40 : 70;
            step($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                 rd_instr_t'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
